// File: rtl/matmul_out_bram_writer.sv
// Buffers matmul result tiles (2-entry FIFO) and drains them lane-by-lane into a BRAM write port
// with row-major tile addressing. Define OUTW_CHECKSUM_EN to add an XOR checksum of all written data.
module matmul_out_bram_writer #(
  parameter int TOTAL_INPUT_W = 2,
  parameter int LANE_W        = 1024,
  parameter int ROW_TILES     = 4,
  parameter int COL_TILES     = 4,
  parameter int ADDR_W        = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [LANE_W-1:0] in_data_i [TOTAL_INPUT_W],
  output logic              in_ready_o,
  output logic              bram_en_o,
  output logic              bram_we_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  output logic [LANE_W-1:0] bram_din_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o
`ifdef OUTW_CHECKSUM_EN
  ,
  output logic [LANE_W-1:0] checksum_o
`endif
);

  localparam int KW = (TOTAL_INPUT_W > 1) ? $clog2(TOTAL_INPUT_W) : 1;
  localparam int RW = (ROW_TILES > 1) ? $clog2(ROW_TILES) : 1;
  localparam int CW = (COL_TILES > 1) ? $clog2(COL_TILES) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, DRAIN, DONE} state_e;

  state_e            state_q;
  logic [1:0]        count_q;
  logic              wr_ptr_q, rd_ptr_q;
  logic [KW-1:0]     lane_q;
  logic [RW-1:0]     row_q;
  logic [CW-1:0]     col_q;
  logic              bram_en_q, bram_we_q, busy_q, done_q, overflow_q;
  logic [ADDR_W-1:0] bram_addr_q;
  logic [LANE_W-1:0] bram_din_q;
  logic [LANE_W-1:0] mem_q [2][TOTAL_INPUT_W];
`ifdef OUTW_CHECKSUM_EN
  logic [LANE_W-1:0] csum_q;
`endif

  logic              active, accept, emit, last_lane, last_tile, pop;
  logic [ADDR_W-1:0] addr_d;
  logic [LANE_W-1:0] din_d;

  assign active     = (state_q == ARMED) || (state_q == DRAIN);
  assign in_ready_o = active && (count_q < 2'd2);
  // start has priority: a tile offered in the same cycle is neither stored nor flagged
  assign accept     = in_valid_i && in_ready_o && !start_i;
  assign emit       = active && (count_q != 2'd0);
  assign last_lane  = (lane_q == KW'(TOTAL_INPUT_W - 1));
  assign pop        = emit && last_lane;
  assign last_tile  = (row_q == RW'(ROW_TILES - 1)) && (col_q == CW'(COL_TILES - 1));

  assign addr_d = ADDR_W'((ADDR_W'(row_q) * ADDR_W'(TOTAL_INPUT_W) + ADDR_W'(lane_q))
                          * ADDR_W'(COL_TILES) + ADDR_W'(col_q));
  assign din_d  = mem_q[rd_ptr_q][lane_q];

  // Tile storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < TOTAL_INPUT_W; k++) mem_q[wr_ptr_q][k] <= in_data_i[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      lane_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      bram_en_q   <= 1'b0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef OUTW_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else if (start_i) begin
      state_q    <= ARMED;
      count_q    <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      lane_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      bram_en_q  <= 1'b0;
      bram_we_q  <= 1'b0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef OUTW_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      bram_en_q <= emit;
      bram_we_q <= emit;
      if (emit) begin
        bram_addr_q <= addr_d;
        bram_din_q  <= din_d;
`ifdef OUTW_CHECKSUM_EN
        csum_q      <= csum_q ^ din_d;
`endif
        lane_q      <= last_lane ? '0 : lane_q + 1'b1;
      end
      if (active && in_valid_i && !in_ready_o) overflow_q <= 1'b1;
      if (accept) wr_ptr_q <= ~wr_ptr_q;
      count_q <= 2'(count_q + 2'(accept) - 2'(pop));

      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        if (col_q == CW'(COL_TILES - 1)) begin
          col_q <= '0;
          row_q <= (row_q == RW'(ROW_TILES - 1)) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end

      if (emit) begin
        if (pop && last_tile)                            state_q <= DONE;
        else if (pop && (count_q == 2'd1) && !accept)    state_q <= ARMED;
        else                                             state_q <= DRAIN;
      end

      // DONE is entered on the final write edge; done/busy flip one cycle later
      if ((state_q == DONE) && !done_q) begin
        done_q <= 1'b1;
        busy_q <= 1'b0;
      end
    end
  end

  assign bram_en_o   = bram_en_q;
  assign bram_we_o   = bram_we_q;
  assign bram_addr_o = bram_addr_q;
  assign bram_din_o  = bram_din_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign overflow_o  = overflow_q;
`ifdef OUTW_CHECKSUM_EN
  assign checksum_o  = csum_q;
`endif

endmodule

// File: tb/tb_matmul_out_bram_writer.sv
// Scoreboard bench for matmul_out_bram_writer: expected BRAM writes are queued when a tile is accepted
// and compared against every write cycle observed on the port.
module tb_matmul_out_bram_writer;
  localparam int TIW = 2, LW = 32, RT = 4, CT = 4, AW = 10;

  logic          clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, in_valid_i = 1'b0;
  logic [LW-1:0] in_data_i [TIW];
  logic          in_ready_o, bram_en_o, bram_we_o, busy_o, done_o, overflow_o;
  logic [AW-1:0] bram_addr_o;
  logic [LW-1:0] bram_din_o;
`ifdef OUTW_CHECKSUM_EN
  logic [LW-1:0] checksum_o;
`endif

  matmul_out_bram_writer #(.TOTAL_INPUT_W(TIW), .LANE_W(LW), .ROW_TILES(RT), .COL_TILES(CT),
                           .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
    .in_ready_o(in_ready_o), .bram_en_o(bram_en_o), .bram_we_o(bram_we_o), .bram_addr_o(bram_addr_o),
    .bram_din_o(bram_din_o), .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o)
`ifdef OUTW_CHECKSUM_EN
    , .checksum_o(checksum_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [LW-1:0] din; } wr_t;
  wr_t           sb_q[$];
  int            wr_cyc_q[$];
  int            checks = 0, failures = 0;
  int            tidx = 0, wr_cnt = 0, cyc = 0, last_wr_cyc = -1, done_cyc = -1;
  bit            done_prev = 1'b0;
  logic [LW-1:0] csum_exp = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    wr_t e;
    @(negedge clk);
    if (bram_we_o) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      wr_cyc_q.push_back(cyc);
      chk("bram_en_on_write", bram_en_o, 1);
      if (sb_q.size() == 0) chk("unexpected_write", bram_we_o, 0);
      else begin
        e = sb_q.pop_front();
        chk("addr", bram_addr_o, e.addr);
        chk("din", bram_din_o, e.din);
        csum_exp ^= e.din;
      end
    end else begin
      chk("bram_en_idle", bram_en_o, 0);
    end
    if (done_o && !done_prev) done_cyc = cyc;
    done_prev = done_o;
  end

  // Drive one tile for one cycle; called at a negedge. Expected writes are the bench's own model
  // of row-major tile addressing.
  task automatic drive_tile(input int t, output bit acc);
    wr_t e;
    int  row, col;
    in_valid_i = 1'b1;
    for (int k = 0; k < TIW; k++) in_data_i[k] = LW'(t * 2 + k);
    acc = in_ready_o && !start_i;
    if (acc) begin
      row = tidx / CT;
      col = tidx % CT;
      for (int k = 0; k < TIW; k++) begin
        e.addr = AW'((row * TIW + k) * CT + col);
        e.din  = LW'(t * 2 + k);
        sb_q.push_back(e);
      end
      tidx++;
    end
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i  = 1'b0;
    sb_q.delete();
    tidx     = 0;
    csum_exp = '0;
  endtask

  task automatic wait_drain(input int n);
    int i = 0;
    while (sb_q.size() != 0 && i < n) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk("drain_timeout", sb_q.size(), 0);
  endtask

  task automatic wait_done(input int n);
    int i = 0;
    while (!done_o && i < n) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk("done_timeout", done_o, 1);
  endtask

  initial begin
    bit acc;
    bit acc_h[16];
    int t, rej, base, dcyc;
    for (int k = 0; k < TIW; k++) in_data_i[k] = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_en", bram_en_o, 0);
    chk("rst_we", bram_we_o, 0);
    chk("rst_addr", bram_addr_o, 0);
    chk("rst_din", bram_din_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_ready", in_ready_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", in_ready_o, 0);

    // full 16-tile run, one tile every 3rd cycle
    do_start();
    chk("armed_busy", busy_o, 1);
    chk("armed_ready", in_ready_o, 1);
    wr_cnt = 0;
    for (int i = 0; i < RT * CT; i++) begin
      drive_tile(i, acc);
      chk("run_accept", acc, 1);
      repeat (2) @(negedge clk);
    end
    wait_drain(20);
    wait_done(10);
    chk("run_wr_cnt", wr_cnt, 32);
    chk("done_latency", done_cyc, last_wr_cyc + 1);
    chk("run_busy", busy_o, 0);
    chk("run_ovf", overflow_o, 0);
`ifdef OUTW_CHECKSUM_EN
    chk("run_csum", checksum_o, csum_exp);
`endif
    drive_tile(99, acc);
    chk("after_done_accept", acc, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("after_done_wr_cnt", wr_cnt, 32);
    chk("after_done_ovf", overflow_o, 0);
    chk("after_done_done", done_o, 1);

    // in_valid held high for 16 cycles
    do_start();
    chk("restart_done", done_o, 0);
    wr_cnt = 0;
    t = 0;
    rej = 0;
    for (int i = 0; i < 16; i++) begin
      drive_tile(100 + t, acc);
      acc_h[i] = acc;
      if (acc) t++;
      else rej++;
      if (i == 1) chk("hold_ovf_clean", overflow_o, 0);
      if (i == 2) chk("hold_ovf_next", overflow_o, 1);
    end
    chk("hold_acc0", acc_h[0], 1);
    chk("hold_acc1", acc_h[1], 1);
    chk("hold_acc2", acc_h[2], 0);
    wait_drain(20);
    chk("hold_ovf", overflow_o, 1);
    chk("hold_rejected", rej > 0, 1);
    chk("hold_wr_cnt", wr_cnt, 2 * t);

    // two back-to-back tiles then pause
    do_start();
    chk("burst_ovf_clr", overflow_o, 0);
    wr_cyc_q.delete();
    dcyc = cyc;
    drive_tile(200, acc);
    chk("burst_acc0", acc, 1);
    drive_tile(201, acc);
    chk("burst_acc1", acc, 1);
    wait_drain(10);
    chk("burst_writes", wr_cyc_q.size(), 4);
    if (wr_cyc_q.size() == 4) begin
      chk("burst_first_lat", wr_cyc_q[0], dcyc + 2);
      chk("burst_no_bubble", wr_cyc_q[3] - wr_cyc_q[0], 3);
    end

    // reset asserted after the 5th write
    do_start();
    base = wr_cnt;
    for (int i = 0; i < 3; i++) begin
      drive_tile(300 + i, acc);
      if (i < 2) repeat (2) @(negedge clk);
    end
    t = 0;
    while (wr_cnt < base + 5 && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("rst5_reached", wr_cnt, base + 5);
    #1 rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("rst5_we", bram_we_o, 0);
    chk("rst5_en", bram_en_o, 0);
    chk("rst5_addr", bram_addr_o, 0);
    chk("rst5_din", bram_din_o, 0);
    chk("rst5_busy", busy_o, 0);
    chk("rst5_ready", in_ready_o, 0);
    base = wr_cnt;
    repeat (3) @(negedge clk);
    #1;
    chk("rst5_no_writes", wr_cnt, base);
    rst_n = 1'b1;
    @(negedge clk);
    do_start();
    drive_tile(400, acc);
    chk("rst5_restart_acc", acc, 1);
    wait_drain(10);

    // start in DRAIN together with in_valid
    do_start();
    drive_tile(500, acc);
    @(negedge clk);
    start_i    = 1'b1;
    in_valid_i = 1'b1;
    for (int k = 0; k < TIW; k++) in_data_i[k] = LW'(600 + k);
    @(negedge clk);
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    sb_q.delete();
    tidx = 0;
    #1;
    base = wr_cnt;
    chk("startwin_ovf", overflow_o, 0);
    chk("startwin_busy", busy_o, 1);
    chk("startwin_ready", in_ready_o, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("startwin_no_writes", wr_cnt, base);
    drive_tile(700, acc);
    chk("startwin_acc", acc, 1);
    wait_drain(10);
    chk("startwin_wr_cnt", wr_cnt, base + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $fatal(1, "timeout");
  end
endmodule
